lcd_responder: RTL

LCD_RESPONDER -- requirements
Module: lcd_responder

---
 rtl/lcd_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_responder.sv
// Memory-mapped HD44780-style LCD write port: a 4-entry command/data FIFO drained
// by a timed SETUP/PULSE/HOLD/WAIT strobe sequencer, plus status and control registers.
module lcd_responder #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sel,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_wren,
    output logic [31:0] o_rdata,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon
);

    // IDLE: waiting for FIFO | SETUP: bus stable, en low | PULSE: en high
    // HOLD: bus held, en low | WAIT: LCD executing the byte
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > T_EXEC_LONG) ? MAX_C : T_EXEC_LONG;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

    logic [8:0]    mem_q [4];
    logic [8:0]    mem_d [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          en_q, en_d;

    logic       wr, push, push_ok, pop, full, empty, busy, is_long;
    logic [8:0] head;
    logic       unused_wdata;

    assign unused_wdata = ^i_wdata[31:8];

    assign wr      = i_sel & i_wren;
    assign push    = wr & ((i_addr == 2'd0) | (i_addr == 2'd1));
    assign full    = (count_q == 3'd4);
    assign empty   = (count_q == 3'd0);
    assign push_ok = push & ~full;
    assign pop     = (state_q == S_IDLE) & ~empty;
    assign busy    = (state_q != S_IDLE);
    assign head    = mem_q[rd_ptr_q];
    // clear and home need the long execution time; data bytes never do
    assign is_long = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        ctrl_d   = ctrl_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {(i_addr == 2'd0), i_wdata[7:0]};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
        if (wr && (i_addr == 2'd2)) begin
            ovf_d = 1'b0;
        end
        if (push && full) begin
            ovf_d = 1'b1;
        end
        if (wr && (i_addr == 2'd3)) begin
            ctrl_d = i_wdata[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    rs_d    = head[8];
                    data_d  = head[7:0];
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = is_long ? LD_LONG : LD_EXEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        en_d = (state_d == S_PULSE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ctrl_q   <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            en_q     <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ctrl_q   <= ctrl_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            en_q     <= en_d;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel) begin
            case (i_addr)
                2'd2:    o_rdata = {25'b0, count_q, ovf_q, empty, full, busy};
                2'd3:    o_rdata = {30'b0, ctrl_q};
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = ctrl_q[0];
    assign o_lcd_blon = ctrl_q[1];

endmodule
